// File: rtl/branch_predict_ctrl.sv
// Fetch-side branch predictor with 2-bit counters and target table.
// Trains on EX resolutions and sequences redirect/flush on mispredict.
module branch_predict_ctrl #(
  parameter int INDEX_BITS   = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_STEP      = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] IF_PC,
  output logic        PredTaken,
  output logic [15:0] PredTarget,
  input  logic        EX_Valid,
  input  logic [15:0] EX_PC,
  input  logic        EX_Taken,
  input  logic [15:0] EX_Target,
  input  logic        EX_PredTaken,
  output logic        Flush,
  output logic        Redirect,
  output logic [15:0] RedirectPC,
  output logic [15:0] BranchCount,
  output logic [15:0] MissCount
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 16 - INDEX_BITS;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  localparam logic [15:0] STEP  = 16'(PC_STEP);
  localparam logic [2:0]  FLOAD = 3'(FLUSH_CYCLES - 1);

  logic              r_valid [ENTRIES];
  logic [1:0]        r_cnt   [ENTRIES];
  logic [TAG_W-1:0]  r_tag   [ENTRIES];
  logic [15:0]       r_tgt   [ENTRIES];

  logic [0:0]  r_state;
  logic [2:0]  r_fcnt;
  logic        r_redirect;
  logic [15:0] r_rpc;
  logic [15:0] r_bcnt;
  logic [15:0] r_mcnt;

  logic [INDEX_BITS-1:0] w_if_idx;
  logic [TAG_W-1:0]      w_if_tag;
  logic                  w_if_hit;
  logic [INDEX_BITS-1:0] w_ex_idx;
  logic [TAG_W-1:0]      w_ex_tag;
  logic                  w_ex_hit;
  logic                  w_accept;
  logic                  w_miss;
  logic [1:0]            w_cnt_cur;
  logic [1:0]            w_cnt_nxt;

  assign w_if_idx = IF_PC[INDEX_BITS-1:0];
  assign w_if_tag = IF_PC[15:INDEX_BITS];
  assign w_ex_idx = EX_PC[INDEX_BITS-1:0];
  assign w_ex_tag = EX_PC[15:INDEX_BITS];

  assign w_if_hit = r_valid[w_if_idx] &&
                    (r_tag[w_if_idx] == w_if_tag);
  assign w_ex_hit = r_valid[w_ex_idx] &&
                    (r_tag[w_ex_idx] == w_ex_tag);

  // Wrong-path resolutions arriving during a flush are dropped.
  assign w_accept = EX_Valid && (r_state == S_IDLE) && !Reset;
  assign w_miss   = w_accept && (EX_PredTaken != EX_Taken);

  assign PredTaken  = w_if_hit && r_cnt[w_if_idx][1];
  assign PredTarget = PredTaken ? r_tgt[w_if_idx]
                                : IF_PC + STEP;

  assign Flush       = (r_state == S_FLUSH);
  assign Redirect    = r_redirect;
  assign RedirectPC  = r_rpc;
  assign BranchCount = r_bcnt;
  assign MissCount   = r_mcnt;

  // Saturating counter step for the resolved entry.
  always_comb begin
    w_cnt_cur = r_cnt[w_ex_idx];
    w_cnt_nxt = w_cnt_cur;
    if (EX_Taken) begin
      if (w_cnt_cur != 2'b11) w_cnt_nxt = w_cnt_cur + 2'b01;
    end else begin
      if (w_cnt_cur != 2'b00) w_cnt_nxt = w_cnt_cur - 2'b01;
    end
  end

  // Table training and allocation on accepted resolutions.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= 2'b01;
        r_tag[i]   <= '0;
        r_tgt[i]   <= '0;
      end
    end else if (w_accept) begin
      if (w_ex_hit) begin
        r_cnt[w_ex_idx] <= w_cnt_nxt;
        if (EX_Taken) r_tgt[w_ex_idx] <= EX_Target;
      end else if (EX_Taken) begin
        r_valid[w_ex_idx] <= 1'b1;
        r_tag[w_ex_idx]   <= w_ex_tag;
        r_cnt[w_ex_idx]   <= 2'b10;
        r_tgt[w_ex_idx]   <= EX_Target;
      end
    end
  end

  // Saturating resolution and mispredict counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_bcnt <= '0;
      r_mcnt <= '0;
    end else begin
      if (w_accept && r_bcnt != 16'hFFFF)
        r_bcnt <= r_bcnt + 16'd1;
      if (w_miss && r_mcnt != 16'hFFFF)
        r_mcnt <= r_mcnt + 16'd1;
    end
  end

  // Recovery FSM: one-cycle redirect, then hold flush.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_fcnt     <= '0;
      r_redirect <= 1'b0;
      r_rpc      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_redirect <= w_miss;
          if (w_miss) begin
            r_state <= S_FLUSH;
            r_fcnt  <= FLOAD;
            r_rpc   <= EX_Taken ? EX_Target : EX_PC + STEP;
          end
        end
        S_FLUSH: begin
          r_redirect <= 1'b0;
          if (r_fcnt == 3'd0) r_state <= S_IDLE;
          else                r_fcnt  <= r_fcnt - 3'd1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_redirect <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Table-driven bench for branch_predict_ctrl with a scoreboard queue.
// Vectors hold one cycle of inputs and the outputs seen in that cycle.
module tb_branch_predict_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] IF_PC;
  logic        PredTaken;
  logic [15:0] PredTarget;
  logic        EX_Valid;
  logic [15:0] EX_PC;
  logic        EX_Taken;
  logic [15:0] EX_Target;
  logic        EX_PredTaken;
  logic        Flush;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic [15:0] BranchCount;
  logic [15:0] MissCount;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  branch_predict_ctrl #(
    .INDEX_BITS  (4),
    .FLUSH_CYCLES(2),
    .PC_STEP     (1)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .IF_PC       (IF_PC),
    .PredTaken   (PredTaken),
    .PredTarget  (PredTarget),
    .EX_Valid    (EX_Valid),
    .EX_PC       (EX_PC),
    .EX_Taken    (EX_Taken),
    .EX_Target   (EX_Target),
    .EX_PredTaken(EX_PredTaken),
    .Flush       (Flush),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .BranchCount (BranchCount),
    .MissCount   (MissCount)
  );

  typedef struct {
    logic        rst;
    logic [15:0] ifpc;
    logic        ev;
    logic [15:0] epc;
    logic        etk;
    logic [15:0] etg;
    logic        epr;
    logic        chk;
    logic        pt;
    logic [15:0] ptg;
    logic        fl;
    logic        rd;
    logic [15:0] rpc;
    logic [15:0] bc;
    logic [15:0] mc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic add(
    input logic rst, input logic [15:0] ifpc,
    input logic ev, input logic [15:0] epc,
    input logic etk, input logic [15:0] etg,
    input logic epr, input logic chk,
    input logic pt, input logic [15:0] ptg,
    input logic fl, input logic rd,
    input logic [15:0] rpc, input logic [15:0] bc,
    input logic [15:0] mc);
    vec_t v;
    v.rst = rst; v.ifpc = ifpc; v.ev = ev;
    v.epc = epc; v.etk = etk; v.etg = etg;
    v.epr = epr; v.chk = chk; v.pt = pt;
    v.ptg = ptg; v.fl = fl; v.rd = rd;
    v.rpc = rpc; v.bc = bc; v.mc = mc;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int idx,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec%0d got %h want %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Reset        = v.rst;
    IF_PC        = v.ifpc;
    EX_Valid     = v.ev;
    EX_PC        = v.epc;
    EX_Taken     = v.etk;
    EX_Target    = v.etg;
    EX_PredTaken = v.epr;
  endtask

  initial begin
    vec_t e;
    int fl_len;
    int rd_cnt;
    bit done;

    // rst ifpc ev epc etk etg epr | chk pt ptg fl rd rpc bc mc
    add(1, 16'h0001, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 16'h0001, 0, 0, 0, 0, 0,   1, 0, 16'h0002, 0, 0, 0, 0, 0);
    add(0, 16'hFFFF, 0, 0, 0, 0, 0,   1, 0, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 16'h0001, 1, 16'h0001, 1, 16'h0010, 0,
        1, 0, 16'h0002, 0, 0, 0, 0, 0);
    add(0, 16'h0001, 0, 0, 0, 0, 0,
        1, 1, 16'h0010, 1, 1, 16'h0010, 1, 1);
    add(0, 16'h0001, 0, 0, 0, 0, 0,
        1, 1, 16'h0010, 1, 0, 0, 1, 1);
    add(0, 16'h0001, 1, 16'h0001, 1, 16'h0010, 1,
        1, 1, 16'h0010, 0, 0, 0, 1, 1);
    add(0, 16'h0001, 1, 16'h0001, 1, 16'h0010, 1,
        1, 1, 16'h0010, 0, 0, 0, 2, 1);
    add(0, 16'h0001, 1, 16'h0001, 0, 16'h0010, 1,
        1, 1, 16'h0010, 0, 0, 0, 3, 1);
    add(0, 16'h0001, 0, 0, 0, 0, 0,
        1, 1, 16'h0010, 1, 1, 16'h0002, 4, 2);
    add(0, 16'h0001, 0, 0, 0, 0, 0,
        1, 1, 16'h0010, 1, 0, 0, 4, 2);
    add(0, 16'h0001, 1, 16'h0011, 1, 16'h0040, 0,
        1, 1, 16'h0010, 0, 0, 0, 4, 2);
    add(0, 16'h0011, 0, 0, 0, 0, 0,
        1, 1, 16'h0040, 1, 1, 16'h0040, 5, 3);
    add(0, 16'h0001, 0, 0, 0, 0, 0,
        1, 0, 16'h0002, 1, 0, 0, 5, 3);
    add(0, 16'h0011, 1, 16'h0011, 0, 16'h0000, 1,
        1, 1, 16'h0040, 0, 0, 0, 5, 3);
    add(0, 16'h0011, 1, 16'h0011, 1, 16'h0077, 0,
        1, 0, 16'h0012, 1, 1, 16'h0012, 6, 4);
    add(0, 16'h0011, 1, 16'h0005, 1, 16'h0099, 0,
        1, 0, 16'h0012, 1, 0, 0, 6, 4);
    add(0, 16'h0011, 0, 0, 0, 0, 0,
        1, 0, 16'h0012, 0, 0, 0, 6, 4);
    add(0, 16'h0005, 0, 0, 0, 0, 0,
        1, 0, 16'h0006, 0, 0, 0, 6, 4);
    add(0, 16'h0011, 1, 16'h0011, 1, 16'h0050, 0,
        1, 0, 16'h0012, 0, 0, 0, 6, 4);
    add(1, 16'h0011, 0, 0, 0, 0, 0,
        1, 1, 16'h0050, 1, 1, 16'h0050, 7, 5);
    add(0, 16'h0011, 0, 0, 0, 0, 0,
        1, 0, 16'h0012, 0, 0, 0, 0, 0);
    add(1, 16'h0003, 1, 16'h0003, 1, 16'h0030, 0,
        1, 0, 16'h0004, 0, 0, 0, 0, 0);
    add(0, 16'h0003, 0, 0, 0, 0, 0,
        1, 0, 16'h0004, 0, 0, 0, 0, 0);
    add(0, 16'h0003, 1, 16'h0003, 1, 16'h0030, 1,
        1, 0, 16'h0004, 0, 0, 0, 0, 0);
    add(0, 16'h0003, 1, 16'h0003, 1, 16'h0031, 1,
        1, 1, 16'h0030, 0, 0, 0, 1, 0);
    add(0, 16'h0003, 0, 0, 0, 0, 0,
        1, 1, 16'h0031, 0, 0, 0, 2, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge Clk);
      #1;
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      #4;
      e = exp_q.pop_front();
      if (e.chk) begin
        check("PredTaken", i, {15'd0, PredTaken}, {15'd0, e.pt});
        check("PredTarget", i, PredTarget, e.ptg);
        check("Flush", i, {15'd0, Flush}, {15'd0, e.fl});
        check("Redirect", i, {15'd0, Redirect}, {15'd0, e.rd});
        if (e.rd)
          check("RedirectPC", i, RedirectPC, e.rpc);
        check("BranchCount", i, BranchCount, e.bc);
        check("MissCount", i, MissCount, e.mc);
      end
    end

    // Mispredict on the trained 0x0003 entry; measure flush window.
    @(posedge Clk);
    #1;
    EX_Valid     = 1'b1;
    EX_PC        = 16'h0003;
    EX_Taken     = 1'b0;
    EX_Target    = 16'h0000;
    EX_PredTaken = 1'b1;
    @(posedge Clk);
    #1;
    EX_Valid = 1'b0;
    fl_len = 0;
    rd_cnt = 0;
    done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      #4;
      if (Flush) fl_len++;
      if (Redirect) begin
        rd_cnt++;
        check("SeqRedirectPC", c, RedirectPC, 16'h0004);
      end
      if (!Flush && fl_len > 0) done = 1'b1;
      else begin
        @(posedge Clk);
        #1;
      end
    end
    check("SeqFlushDone", 0, {15'd0, done}, 16'd1);
    check("SeqFlushLen", 0, 16'(fl_len), 16'd2);
    check("SeqRedirectCnt", 0, 16'(rd_cnt), 16'd1);
    check("SeqBranchCount", 0, BranchCount, 16'd3);
    check("SeqMissCount", 0, MissCount, 16'd1);
    check("SeqPredTaken", 0, {15'd0, PredTaken}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
Fetch-side branch prediction and misprediction-recovery controller for the 16-bit pipelined core.
- Holds a direct-mapped table of 2-bit saturating counters with branch targets, indexed by PC.
- Supplies the taken prediction to IF; that prediction travels down the pipe and returns as the EX branch unit's BranchTaken input.
- Consumes the EX branch resolution, trains the table, and sequences redirect and multi-cycle flush on a mispredict.

Parameters:
INDEX_BITS, 4, table index width (2^INDEX_BITS entries); tag = PC[15:INDEX_BITS]
FLUSH_CYCLES, 2, cycles Flush is held after a mispredict (legal range 1..7)
PC_STEP, 1, sequential PC increment (word addressed)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  synchronous, active-high reset
IF_PC  input  16  PC currently in fetch
PredTaken  output  1  prediction for IF_PC
PredTarget  output  16  predicted next PC for IF_PC
EX_Valid  input  1  branch/jump resolved in EX this cycle
EX_PC  input  16  PC of the resolved instruction
EX_Taken  input  1  actual outcome (branch unit ShouldBranch)
EX_Target  input  16  resolved target (branch unit BranchTargetAddr)
EX_PredTaken  input  1  prediction that was made for that instruction
Flush  output  1  kill IF/ID (and ID/EX) contents
Redirect  output  1  one-cycle pulse: load RedirectPC into PC
RedirectPC  output  16  correct next PC, valid when Redirect=1
BranchCount  output  16  saturating count of accepted resolutions
MissCount  output  16  saturating count of mispredictions

Behaviour:
- Reset (synchronous, Clk edge with Reset=1):
  - All entries: valid=0, counter=2'b01, target=0, tag=0.
  - FSM to IDLE; Flush=0, Redirect=0, RedirectPC=0, both counts 0.
  - Reset dominates every simultaneous event.
- Lookup (combinational from registered table, same cycle):
  - hit = valid[idx] && tag[idx]==IF_PC[15:INDEX_BITS].
  - PredTaken = hit && counter[1].
  - PredTarget = PredTaken ? target : IF_PC+PC_STEP (16-bit wrap, 0xFFFF+1=0x0000).
- Accept: resolution is accepted when EX_Valid=1, FSM=IDLE and Reset=0.
  - In FLUSH, EX_Valid is ignored: no training, no count, no redirect (the instruction is wrong-path).
- Training (accepted resolution, registered at edge):
  - EX hit: counter +1 if EX_Taken else -1, saturating at 00/11; target <= EX_Target when EX_Taken.
  - EX miss and EX_Taken: allocate/replace: valid=1, tag, counter=2'b10, target=EX_Target.
  - EX miss and not taken: table unchanged.
  - Read and write to the same index in one cycle: lookup sees the pre-update value.
- Mispredict: miss = accepted && (EX_PredTaken != EX_Taken).
  - Target mismatch is not a miss in this block.
  - BranchCount +1 on every accepted resolution; MissCount +1 on miss; both hold at 0xFFFF.
- FSM IDLE/FLUSH:
  - IDLE -> FLUSH on miss. Next cycle: Redirect=1 for exactly one cycle, RedirectPC = EX_Taken ? EX_Target : EX_PC+PC_STEP (captured at the miss edge), Flush=1.
  - Flush held for exactly FLUSH_CYCLES consecutive cycles; a down-counter is loaded with FLUSH_CYCLES-1.
  - FLUSH -> IDLE when the counter reaches 0; EX_Valid is accepted again in the first IDLE cycle.
  - Redirect and Flush are registered outputs; no combinational path from EX_* to them.
- Reset mid-FLUSH: Flush and Redirect are 0 after that edge.
- Reset in the same cycle as a miss: no flush and no training.

Test Plan:
1. Reset, IF_PC=0x0001 -> PredTaken=0, PredTarget=0x0002, Flush=0, Redirect=0, counts 0; IF_PC=0xFFFF -> PredTarget=0x0000.
2. EX_Valid=1, EX_PC=0x0001, EX_Taken=1, EX_Target=0x0010, EX_PredTaken=0 -> next cycle Redirect=1 and RedirectPC=0x0010 (one cycle); Flush=1 for exactly 2 cycles; MissCount=1, BranchCount=1. Then IF_PC=0x0001 -> PredTaken=1, PredTarget=0x0010.
3. Two correct taken resolutions of 0x0001 (counter 10->11->11) -> no Flush, BranchCount=3. Then taken=0 with EX_PredTaken=1 -> Redirect to 0x0002, MissCount=2. Counter now 10, so IF_PC=0x0001 still predicts taken.
4. Alias: EX_PC=0x0011 taken to 0x0040 (same index, new tag) -> IF_PC=0x0011 predicts 0x0040; IF_PC=0x0001 -> PredTaken=0, PredTarget=0x0002.
5. Mispredict, then EX_Valid=1 with a conflicting outcome during both FLUSH cycles -> no second Redirect, Flush length still 2, counts and table unchanged.
6. Reset asserted in the first FLUSH cycle -> Flush=0 and Redirect=0 next cycle. Separately, Reset coinciding with a miss -> no flush, MissCount=0.
